// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 state encoding, frame length and keyboard command bytes.
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE} ps2_state_t;
  localparam int PS2_FRAME_BITS = 11;
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] CMD_RESET = 8'hFF;
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: synchronizes the PS/2 clock and data lines and flags keyb_clk falling edges.
module ps2_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clk,
  input  logic i_data,
  output logic o_clk,
  output logic o_data,
  output logic o_fall
);
  logic [SYNC_STAGES-1:0] r_clk_sync, r_data_sync;
  logic r_clk_prev;
  // Lines idle high, so reset to 1 to avoid a phantom edge after reset.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_clk_sync <= '1;
      r_data_sync <= '1;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], i_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_data};
      r_clk_prev <= o_clk;
    end
  assign o_clk = r_clk_sync[SYNC_STAGES-1];
  assign o_data = r_data_sync[SYNC_STAGES-1];
  assign o_fall = r_clk_prev & ~o_clk;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter with open-drain pull-low enables.
// Optional watchdog enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 12000,
`ifdef PS2_TX_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
`endif
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       keyb_clk_in,
  input  logic       keyb_data_in,
  output logic       keyb_clk_oe,
  output logic       keyb_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  ps2_state_t r_state, w_next;
  logic [IW-1:0] r_cnt;
  logic [8:0] r_sr;
  logic [3:0] r_bit;
  logic r_data_oe, r_err;
  logic w_clk_s, w_data_s, w_fall, w_inh_last, w_to;

  ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .reset(reset), .i_clk(keyb_clk_in), .i_data(keyb_data_in),
    .o_clk(w_clk_s), .o_data(w_data_s), .o_fall(w_fall)
  );

  assign w_inh_last = r_state == INHIBIT && r_cnt == IW'(INHIBIT_CYCLES - 1);

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_to;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_to <= '0;
    else r_to <= (r_state == IDLE || r_state == INHIBIT) ? '0 : r_to + 1'b1;
  assign w_to = r_state != IDLE && r_state != INHIBIT && r_to == TW'(TIMEOUT_CYCLES);
`else
  assign w_to = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    keyb_clk_oe = 1'b0;
    keyb_data_oe = 1'b0;
    tx_done = 1'b0;
    case (r_state)
      IDLE: w_next = tx_valid ? INHIBIT : IDLE;
      INHIBIT: begin
        keyb_clk_oe = 1'b1;
        keyb_data_oe = w_inh_last;
        w_next = w_inh_last ? REQ : INHIBIT;
      end
      REQ: begin
        keyb_data_oe = 1'b1;
        w_next = w_fall ? SHIFT : REQ;
      end
      SHIFT: begin
        keyb_data_oe = r_data_oe;
        w_next = (w_fall && r_bit == 4'(PS2_FRAME_BITS - 2)) ? ACK : SHIFT;
      end
      ACK: w_next = w_fall ? WAIT_IDLE : ACK;
      WAIT_IDLE: begin
        tx_done = w_clk_s & w_data_s;
        w_next = tx_done ? IDLE : WAIT_IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (w_to) begin
      w_next = IDLE;
      tx_done = 1'b1;
      keyb_clk_oe = 1'b0;
      keyb_data_oe = 1'b0;
    end
  end

  // Ones shift in behind the parity bit so the stop bit releases the data line.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_sr <= '1;
      r_cnt <= '0;
      r_bit <= '0;
      r_data_oe <= 1'b0;
      r_err <= 1'b0;
    end else
      case (r_state)
        IDLE:
          if (tx_valid) begin
            r_sr <= {odd_parity(tx_data), tx_data};
            r_cnt <= '0;
            r_err <= 1'b0;
          end
        INHIBIT: r_cnt <= r_cnt + 1'b1;
        REQ, SHIFT:
          if (w_fall) begin
            r_data_oe <= ~r_sr[0];
            r_sr <= {1'b1, r_sr[8:1]};
            r_bit <= r_state == REQ ? 4'd1 : r_bit + 4'd1;
          end
        ACK:
          if (w_fall) begin
            r_bit <= 4'(PS2_FRAME_BITS);
            r_err <= w_data_s;
          end
        default: ;
      endcase

  assign tx_err = tx_done & (r_err | w_to);
  assign tx_ready = r_state == IDLE;
  assign busy = r_state != IDLE;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with an open-drain bus and a clocking PS/2 device model.
module tb_ps2_host_tx;
  import ps2_pkg::*;
  logic clk = 0, reset = 0, tx_valid = 0;
  logic [7:0] tx_data = 0;
  logic dev_clk = 1, dev_data = 1;
  logic tx_ready, keyb_clk_oe, keyb_data_oe, busy, tx_done, tx_err;
  logic [9:0] cap;
  int n_vec = 0, n_err = 0;
  wire kc = dev_clk & ~keyb_clk_oe;
  wire kd = dev_data & ~keyb_data_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(10),
`ifdef PS2_TX_TIMEOUT_EN
    .TIMEOUT_CYCLES(500),
`endif
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .keyb_clk_in(kc), .keyb_data_in(kd), .keyb_clk_oe(keyb_clk_oe), .keyb_data_oe(keyb_data_oe),
    .busy(busy), .tx_done(tx_done), .tx_err(tx_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start(input logic [7:0] d, input bit poke);
    int n = 0;
    logic last_doe = 0, rdy_seen = 0;
    @(negedge clk);
    tx_data = d;
    tx_valid = 1;
    @(negedge clk);
    tx_valid = poke;
    if (poke) tx_data = CMD_ENABLE;
    while (keyb_clk_oe && n < 100) begin
      last_doe = keyb_data_oe;
      rdy_seen |= tx_ready;
      n++;
      @(negedge clk);
    end
    tx_valid = 0;
    chk("inhibit_len", n, 10);
    chk("start_bit_oe", last_doe, 1);
    chk("req_data_oe", keyb_data_oe, 1);
    chk("busy", busy, 1);
    if (poke) chk("ready_while_busy", rdy_seen, 0);
  endtask

  task automatic dev_bit(output logic b);
    repeat (20) @(negedge clk);
    dev_clk = 0;
    repeat (20) @(negedge clk);
    dev_clk = 1;
    b = kd;
  endtask

  task automatic frame(input bit ack);
    logic b;
    for (int i = 0; i < 10; i++) begin
      dev_bit(b);
      cap[i] = b;
    end
    dev_data = ~ack;
    dev_bit(b);
    dev_data = 1;
  endtask

  task automatic finish(input logic [7:0] d, input logic par, input logic err);
    int n = 0;
    chk("data", cap[7:0], d);
    chk("parity", cap[8], par);
    chk("stop", cap[9], 1);
    while (!tx_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("done", tx_done, 1);
    chk("err", tx_err, err);
    chk("ready_at_done", tx_ready, 0);
    @(negedge clk);
    chk("done_pulse", tx_done, 0);
    chk("ready_after", tx_ready, 1);
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    logic b;
    #1 reset = 1;
    #2;
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_clk_oe", keyb_clk_oe, 0);
    chk("rst_data_oe", keyb_data_oe, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_err", tx_err, 0);
    @(negedge clk);
    reset = 0;
    start(CMD_SET_LEDS, 0); frame(1); finish(8'hED, 1, 0);
    start(8'h01, 0); frame(1); finish(8'h01, 0, 0);
    start(8'hFF, 0); frame(1); finish(8'hFF, 1, 0);
    start(8'h00, 0); frame(1); finish(8'h00, 1, 0);
    start(8'h55, 0); frame(0); finish(8'h55, 1, 1);
    start(CMD_SET_LEDS, 1); frame(1); finish(8'hED, 1, 0);
    start(8'hA5, 0);
    for (int i = 0; i < 4; i++) dev_bit(b);
    chk("pre_reset_data_oe", keyb_data_oe, 1);
    #2 reset = 1;
    #1;
    chk("async_clk_oe", keyb_clk_oe, 0);
    chk("async_data_oe", keyb_data_oe, 0);
    chk("async_busy", busy, 0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("post_reset_ready", tx_ready, 1);
    start(CMD_RESET, 0); frame(1); finish(8'hFF, 1, 0);
`ifdef PS2_TX_TIMEOUT_EN
    begin
      int n = 0;
      start(CMD_ENABLE, 0);
      while (!tx_done && n < 1000) begin
        @(negedge clk);
        n++;
      end
      chk("timeout_cycles", n, 500);
      chk("timeout_err", tx_err, 1);
      chk("timeout_clk_oe", keyb_clk_oe, 0);
      chk("timeout_data_oe", keyb_data_oe, 0);
      @(negedge clk);
      chk("timeout_ready", tx_ready, 1);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends one command byte (for example 0xED set-LEDs, 0xFF reset, 0xF4 enable) from the FPGA to the keyboard over the same keyb_clk/keyb_data lines the keyboard receiver uses. It drives both lines open-drain through active-high pull-low enables, and its result feeds the keyboard control logic next to the receiver.

Parameters:
- INHIBIT_CYCLES, 12000: clk cycles keyb_clk is held low before the request (120 us at 100 MHz).
- TIMEOUT_CYCLES, 2000000: watchdog limit in clk cycles (20 ms); used only with PS2_TX_TIMEOUT_EN.
- SYNC_STAGES, 2: synchronizer depth on keyb_clk_in and keyb_data_in.

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  asynchronous, active-high reset.
- tx_data  in  8  command byte to send.
- tx_valid  in  1  request; accepted when tx_valid=1 and tx_ready=1 in the same cycle.
- tx_ready  out  1  idle, can accept a byte.
- keyb_clk_in  in  1  sampled PS/2 clock line.
- keyb_data_in  in  1  sampled PS/2 data line.
- keyb_clk_oe  out  1  1 = pull keyb_clk low; 0 = release (high-Z).
- keyb_data_oe  out  1  1 = pull keyb_data low; 0 = release.
- busy  out  1  transfer in progress.
- tx_done  out  1  one-cycle pulse at end of transfer.
- tx_err  out  1  one-cycle pulse together with tx_done on a missing ACK or a timeout.

Behaviour:
- Reset values: tx_ready=1, busy=0, keyb_clk_oe=0, keyb_data_oe=0, tx_done=0, tx_err=0, state IDLE.
- Reset is asynchronous, so both lines are released in the same instant reset rises, including mid-transfer.
- Inputs pass through SYNC_STAGES flops. A keyb_clk falling edge is a registered 1-to-0 transition of the synchronized clock.
- Frame: start bit 0, d0..d7 LSB first, odd parity (parity = ~^tx_data), stop bit 1, then the device ACK.
- On accept, latch tx_data and its parity into a 9-bit shift register.
- tx_ready=0 while busy=1. tx_valid while busy is ignored and not queued.
- States:
  - IDLE: tx_ready=1. On accept → INHIBIT.
  - INHIBIT: keyb_clk_oe=1 for exactly INHIBIT_CYCLES cycles. keyb_data_oe=1 in the last cycle (start bit). Then → REQ.
  - REQ: keyb_clk_oe=0, keyb_data_oe=1. On the 1st falling edge, drive d0 → SHIFT.
  - SHIFT: on each falling edge, present the next bit (keyb_data_oe = ~bit). Order: d1..d7, then parity on edge 9, then release data for the stop bit on edge 10 → ACK.
  - ACK: on the 11th falling edge, sample keyb_data_in. 0 = ACK good; 1 = error flag set → WAIT_IDLE.
  - WAIT_IDLE: wait until the synchronized keyb_clk and keyb_data are both 1. Then pulse tx_done (tx_err = error flag) → IDLE.
- Bit-edge counter is 4-bit, 1..11. A counter value outside 1..11 cannot occur.
- Falling edges in IDLE and INHIBIT are ignored.
- tx_done is asserted the cycle before tx_ready returns to 1. A new accept is possible in the cycle after tx_done.

Optional Feature:
PS2_TX_TIMEOUT_EN
- Defined: a counter starts at REQ entry. If it reaches TIMEOUT_CYCLES before WAIT_IDLE completes, the block:
  - releases both lines;
  - pulses tx_done and tx_err in the same cycle;
  - goes to IDLE.
- Undefined: no watchdog; the block waits indefinitely for device clocks.

Decomposition:
- Package ps2_pkg holds:
  - state enum (IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE);
  - PS2_FRAME_BITS=11;
  - command constants: CMD_SET_LEDS=8'hED, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF.
- Sub-module ps2_sync_edge holds the synchronizer plus falling-edge detector. The keyboard receiver shares it.

Test Plan (INHIBIT_CYCLES=10, TIMEOUT_CYCLES=500; the bench device model clocks at 20-clk half periods):
1. tx_data=8'hED → keyb_clk_oe high exactly 10 cycles; data_oe set before the clock is released. Device captures bits 1,0,1,1,0,1,1,1, then parity 1 and stop 1. Device ACKs → tx_done=1 and tx_err=0 for one cycle.
2. tx_data=8'h01 → parity 0. tx_data=8'hFF → parity 1. tx_data=8'h00 → parity 1. All three captured by the device model.
3. Device holds data high at the ACK → tx_done=1 with tx_err=1.
4. Second tx_valid (8'hF4) during the 8'hED transfer → ignored. Only 0xED appears on the bus, and tx_ready stays 0 until after tx_done.
5. reset asserted after the 4th data bit → keyb_clk_oe=0, keyb_data_oe=0, busy=0 with no clk edge needed. After release, tx_ready=1 and a new 8'hFF transfers correctly.
6. With PS2_TX_TIMEOUT_EN and a device that never clocks → tx_done and tx_err pulse 500 cycles after REQ entry, and both lines are released.
